// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared CPU bus command codes
package mem_bus_responder_pkg;

  localparam logic [3:0] BUS_IDLE       = 4'hF;
  localparam logic [3:0] BUS_READ       = 4'b1001;
  localparam logic [3:0] BUS_WRITE      = 4'b1010;
  localparam logic [3:0] BUS_WRITE_BYTE = 4'b1011;

  function automatic logic is_bus_cmd(input logic [3:0] status);
    return (status == BUS_READ) || (status == BUS_WRITE) || (status == BUS_WRITE_BYTE);
  endfunction

endpackage

// File: rtl/mem_bus_responder_byte_ram.sv
// rtl/mem_bus_responder_byte_ram.sv - even/odd byte-bank RAM with independent bank addresses
module v30_byte_ram #(
  parameter int BANK_ADDR_BITS = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BANK_ADDR_BITS-1:0] even_addr,
  input  logic [7:0]                even_wdata,
  input  logic                      even_we,
  input  logic                      even_re,
  output logic [7:0]                even_rdata,
  input  logic [BANK_ADDR_BITS-1:0] odd_addr,
  input  logic [7:0]                odd_wdata,
  input  logic                      odd_we,
  input  logic                      odd_re,
  output logic [7:0]                odd_rdata
);

  localparam int DEPTH = 1 << BANK_ADDR_BITS;

  logic [7:0] even_mem [DEPTH];
  logic [7:0] odd_mem  [DEPTH];

  // Storage has no reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (even_we) even_mem[even_addr] <= even_wdata;
    if (odd_we)  odd_mem[odd_addr]   <= odd_wdata;
  end

  // Read registers only load on a read, so they hold between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      even_rdata <= '0;
      odd_rdata  <= '0;
    end else begin
      if (even_re) even_rdata <= even_mem[even_addr];
      if (odd_re)  odd_rdata  <= odd_mem[odd_addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU memory bus responder with wait states and byte-banked store
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int WAIT_STATES   = 1,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_out,
  input  logic [3:0]  bus_status,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  output logic        readyb
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state;
  logic [3:0]               wait_cnt;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [15:0]              wdata_q;
  logic [3:0]               cmd_q;
  logic                     rd_swap;

  logic                     cmd_valid;
  logic [MEM_ADDR_BITS-1:0] cur_addr;
  logic [MEM_ADDR_BITS-1:0] next_addr;
  logic [15:0]              cur_wdata;
  logic [3:0]               cur_cmd;
  logic                     enter_done;
  logic                     word_wr, byte_wr, rd_en;
  logic                     even_we, odd_we;
  logic [7:0]               even_wdata, odd_wdata, even_rdata, odd_rdata;

  generate
    if (MEM_ADDR_BITS < 20) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^address_out[19:MEM_ADDR_BITS];
    end
  endgenerate

  // With zero wait states the memory access happens on the acceptance edge,
  // so the live bus is used in IDLE and the captured copy afterwards.
  always_comb begin
    cmd_valid  = is_bus_cmd(bus_status);
    cur_addr   = (state == IDLE) ? address_out[MEM_ADDR_BITS-1:0] : addr_q;
    cur_wdata  = (state == IDLE) ? data_out : wdata_q;
    cur_cmd    = (state == IDLE) ? bus_status : cmd_q;
    next_addr  = cur_addr + 1'b1;
    enter_done = !reset &&
                 (((state == IDLE) && cmd_valid && (WAIT_STATES == 0)) ||
                  ((state == BUSY) && (wait_cnt == 4'd1)));
    word_wr    = enter_done && (cur_cmd == BUS_WRITE);
    byte_wr    = enter_done && (cur_cmd == BUS_WRITE_BYTE);
    rd_en      = enter_done && (cur_cmd == BUS_READ);
    even_we    = word_wr || (byte_wr && !cur_addr[0]);
    odd_we     = word_wr || (byte_wr && cur_addr[0]);
    even_wdata = cur_addr[0] ? cur_wdata[15:8] : cur_wdata[7:0];
    odd_wdata  = cur_addr[0] ? cur_wdata[7:0]  : cur_wdata[15:8];
    readyb     = !((state == DONE) || ((state == IDLE) && !cmd_valid));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_q    <= BUS_IDLE;
      rd_swap  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q   <= address_out[MEM_ADDR_BITS-1:0];
          wdata_q  <= data_out;
          cmd_q    <= bus_status;
          wait_cnt <= 4'(WAIT_STATES);
          state    <= (WAIT_STATES == 0) ? DONE : BUSY;
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rd_en) rd_swap <= cur_addr[0];
    end
  end

  // Byte A lives in the bank picked by A[0]; the even bank always holds
  // whichever of A, A+1 is even, which is index (A+1)>>1 in both cases.
  v30_byte_ram #(.BANK_ADDR_BITS(MEM_ADDR_BITS - 1)) u_ram (
    .clk        (clk),
    .reset      (reset),
    .even_addr  (next_addr[MEM_ADDR_BITS-1:1]),
    .even_wdata (even_wdata),
    .even_we    (even_we),
    .even_re    (rd_en),
    .even_rdata (even_rdata),
    .odd_addr   (cur_addr[MEM_ADDR_BITS-1:1]),
    .odd_wdata  (odd_wdata),
    .odd_we     (odd_we),
    .odd_re     (rd_en),
    .odd_rdata  (odd_rdata)
  );

  assign data_in = rd_swap ? {even_rdata, odd_rdata} : {odd_rdata, even_rdata};

endmodule
